// File: rtl/sync_fifo_lp.sv
// Single-clock FIFO with block enable, registered status flags and sticky error flags.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; default is a registered read port.
module sync_fifo_lp #(
    parameter int DEPTH    = 8,
    parameter int WIDTH    = 32,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     fifo_en,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     rd_valid,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow,
    input  logic                     err_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0] AF_C    = (AW+1)'(AF_LEVEL);
    localparam logic [AW:0] AE_C    = (AW+1)'(AE_LEVEL);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr;
    logic [AW:0]      wr_ptr_nxt, rd_ptr_nxt, count_nxt;
    logic             rd_acc, wr_acc, ovf_evt, udf_evt;

    // A write into a full FIFO is only legal when a read frees a slot on the same edge.
    always_comb begin
        rd_acc     = fifo_en & rd_en & ~empty;
        wr_acc     = fifo_en & wr_en & (~full | rd_acc);
        ovf_evt    = fifo_en & wr_en & ~wr_acc;
        udf_evt    = fifo_en & rd_en & empty;
        wr_ptr_nxt = wr_ptr + (AW+1)'(wr_acc);
        rd_ptr_nxt = rd_ptr + (AW+1)'(rd_acc);
        count_nxt  = wr_ptr_nxt - rd_ptr_nxt;
    end

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    // Flags are derived from the next-state count so they never lag the pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            wr_ptr       <= wr_ptr_nxt;
            rd_ptr       <= rd_ptr_nxt;
            count        <= count_nxt;
            full         <= (count_nxt == DEPTH_C);
            empty        <= (count_nxt == '0);
            almost_full  <= (count_nxt >= AF_C);
            almost_empty <= (count_nxt <= AE_C);
            if (fifo_en) begin
                overflow  <= (overflow & ~err_clr) | ovf_evt;
                underflow <= (underflow & ~err_clr) | udf_evt;
            end
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    assign rd_data  = mem[rd_ptr[AW-1:0]];
    assign rd_valid = ~empty;
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_acc;
            if (rd_acc) begin
                rd_data <= mem[rd_ptr[AW-1:0]];
            end
        end
    end
`endif

endmodule

// File: tb/tb_sync_fifo_lp.sv
// Randomised scoreboard bench for sync_fifo_lp: a queue-based model predicts flags and read data,
// a negedge monitor consumes expected read words whenever the DUT presents one.
module tb_sync_fifo_lp;

    localparam int DEPTH = 8;
    localparam int WIDTH = 32;
    localparam int AF    = DEPTH - 2;
    localparam int AE    = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             fifo_en = 1'b0;
    logic             wr_en = 1'b0;
    logic             rd_en = 1'b0;
    logic             err_clr = 1'b0;
    logic [WIDTH-1:0] wr_data = '0;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
    logic [3:0]       count;

    int n_cmp = 0;
    int n_err = 0;

    logic [WIDTH-1:0] model_q [$];
    logic [WIDTH-1:0] exp_q [$];
    bit               m_ovf = 1'b0;
    bit               m_udf = 1'b0;

    always #5 clk = ~clk;

    sync_fifo_lp #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
        .clk(clk), .rst_n(rst_n), .fifo_en(fifo_en), .wr_en(wr_en), .wr_data(wr_data),
        .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
        .overflow(overflow), .underflow(underflow), .err_clr(err_clr)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, req, $time);
        end
    endtask

    task automatic check_state(input bit racc);
        int sz;
        sz = model_q.size();
        chk("count", 32'(count), sz);
        chk("full", 32'(full), 32'(sz == DEPTH));
        chk("empty", 32'(empty), 32'(sz == 0));
        chk("almost_full", 32'(almost_full), 32'(sz >= AF));
        chk("almost_empty", 32'(almost_empty), 32'(sz <= AE));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("underflow", 32'(underflow), 32'(m_udf));
`ifdef SYNC_FIFO_FWFT_EN
        chk("rd_valid", 32'(rd_valid), 32'(sz != 0));
`else
        chk("rd_valid", 32'(rd_valid), 32'(racc));
`endif
    endtask

    // One clock of stimulus: predict from the model, apply, then compare state after the edge.
    task automatic step(input bit en, input bit wr, input bit rd, input bit clr,
                        input logic [31:0] d);
        bit racc, wacc;
        int sz;
        fifo_en = en; wr_en = wr; rd_en = rd; err_clr = clr; wr_data = d;
        sz   = model_q.size();
        racc = en && rd && (sz > 0);
        wacc = en && wr && ((sz < DEPTH) || racc);
        if (racc) exp_q.push_back(model_q.pop_front());
        if (wacc) model_q.push_back(d);
        if (en) begin
            m_ovf = (m_ovf && !clr) || (wr && !wacc);
            m_udf = (m_udf && !clr) || (rd && (sz == 0));
        end
        @(posedge clk);
        #1;
        check_state(racc);
    endtask

    task automatic check_reset_values();
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_almost_empty", 32'(almost_empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_almost_full", 32'(almost_full), 0);
        chk("rst_rd_valid", 32'(rd_valid), 0);
        chk("rst_overflow", 32'(overflow), 0);
        chk("rst_underflow", 32'(underflow), 0);
`ifndef SYNC_FIFO_FWFT_EN
        chk("rst_rd_data", rd_data, 0);
`endif
    endtask

    task automatic random_phase(input int pw, input int pr, input int n);
        for (int i = 0; i < n; i++) begin
            step($urandom_range(0, 9) != 0, $urandom_range(0, 99) < pw,
                 $urandom_range(0, 99) < pr, $urandom_range(0, 24) == 0, $urandom);
        end
    endtask

    // Monitor: consumes one expected word each time the DUT presents read data.
    initial begin
        logic [31:0] last_exp;
        logic [31:0] e;
        last_exp = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                last_exp = '0;
            end else begin
`ifdef SYNC_FIFO_FWFT_EN
                if (rd_valid && fifo_en && rd_en) begin
`else
                if (rd_valid) begin
`endif
                    if (exp_q.size() == 0) begin
                        chk("rd_unexpected", 32'(rd_valid), 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rd_data", rd_data, e);
                        last_exp = e;
                    end
                end
`ifndef SYNC_FIFO_FWFT_EN
                else begin
                    chk("rd_hold", rd_data, last_exp);
                end
`endif
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_reset_values();
        rst_n = 1'b1;

        // Fill with 0..7, then a rejected ninth write.
        for (int i = 0; i < DEPTH + 1; i++) step(1, 1, 0, 0, (i < DEPTH) ? i : 32'hFF);
        // Drain in order, then a read on empty.
        for (int i = 0; i < DEPTH + 1; i++) step(1, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0);

        // Clear errors, refill, then sustained simultaneous read/write across the wrap.
        step(1, 0, 0, 1, 0);
        for (int i = 0; i < DEPTH; i++) step(1, 1, 0, 0, $urandom);
        for (int i = 0; i < 20; i++) step(1, 1, 1, 0, $urandom);
        step(1, 1, 0, 0, $urandom);
        for (int i = 0; i < DEPTH + 1; i++) step(1, 0, 1, 0, 0);

        // Disabled block ignores requests and holds errors; then clear.
        for (int i = 0; i < 3; i++) step(1, 1, 0, 0, $urandom);
        for (int i = 0; i < 5; i++) step(0, 1, 1, 0, $urandom);
        step(1, 0, 0, 1, 0);
        // Clear racing a fresh underflow-free overflow event keeps overflow set.
        for (int i = 0; i < DEPTH; i++) step(1, 1, 0, 0, $urandom);
        step(1, 1, 0, 1, $urandom);
        for (int i = 0; i < DEPTH; i++) step(1, 0, 1, 0, 0);

`ifdef SYNC_FIFO_FWFT_EN
        step(1, 1, 0, 0, 32'hA5);
        chk("fwft_head", rd_data, 32'hA5);
        step(1, 0, 1, 0, 0);
`endif

        for (int ph = 0; ph < 8; ph++) random_phase((ph % 2) ? 30 : 80, (ph % 2) ? 80 : 30, 80);

        // Mid-stream reset with data held.
        for (int i = 0; i < 5; i++) step(1, 1, 0, 0, $urandom);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        rst_n = 1'b0;
        model_q.delete();
        exp_q.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
        #1;
        check_reset_values();
        repeat (2) @(posedge clk);
        #1;
        check_reset_values();
        rst_n = 1'b1;

        for (int ph = 0; ph < 4; ph++) random_phase((ph % 2) ? 25 : 75, (ph % 2) ? 75 : 25, 60);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);
        chk("exp_q_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
